x_300_mod_241_stream: RTL and testbench



---
 rtl/x_300_mod_241_stream_pkg.sv | 19 +
 rtl/x_300_mod_241_stream_if.sv | 41 ++++
 rtl/x_300_mod_241.sv | 29 ++
 rtl/x_300_mod_241_stream.sv | 106 ++++++++++
 tb/tb_x_300_mod_241_stream.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/x_300_mod_241_stream_pkg.sv
// Shared constants and types for the 300-bit mod-241 streaming front-end.
package x_mod_241_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned N_BITS = 300;
  localparam int unsigned BEATS  = 10;
  localparam int unsigned MOD    = 241;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned CNT_W  = 4;
  // Bits of the final beat that land in the operand.
  localparam int unsigned LAST_W = N_BITS - (BEATS - 1) * WORD_W;

  typedef enum logic [1:0] {
    COLLECT,
    CALC,
    HOLD
  } state_e;

endpackage

// File: rtl/x_300_mod_241_stream_if.sv
// Handshake bundle for the mod-241 stream block.
// Signals:
//   in_valid/in_ready/in_data/in_last - operand word stream, LSB-first
//   out_valid/out_ready/out_res/out_trunc - residue stream
// Modports:
//   slave  - the stream block (consumes words, produces residues)
//   master - the environment (produces words, consumes residues)
interface x_300_mod_241_stream_if;

  logic                                in_valid;
  logic                                in_ready;
  logic [x_mod_241_pkg::WORD_W-1:0]    in_data;
  logic                                in_last;
  logic                                out_valid;
  logic                                out_ready;
  logic [x_mod_241_pkg::RES_W-1:0]     out_res;
  logic                                out_trunc;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_res,
    output out_trunc
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_res,
    input  out_trunc
  );

endinterface

// File: rtl/x_300_mod_241.sv
// Combinational reducer: r = x mod 241.
// Ports:
//   x - 300-bit operand
//   r - 8-bit residue, 0..240
module x_300_mod_241
  import x_mod_241_pkg::*;
(
  input  logic [N_BITS-1:0] x,
  output logic [RES_W-1:0]  r
);

  localparam int unsigned NBytes = (N_BITS + 7) / 8;

  logic [NBytes*8-1:0] x_pad;
  logic [15:0]         acc;

  assign x_pad = {{(NBytes * 8 - N_BITS){1'b0}}, x};

  // Horner evaluation over bytes, MSB first. acc stays below 241, so
  // acc*256 + 255 always fits in 16 bits.
  always_comb begin
    acc = '0;
    for (int i = NBytes - 1; i >= 0; i--) begin
      acc = ({acc[7:0], 8'h00} + {8'h00, x_pad[i*8 +: 8]}) % 16'(MOD);
    end
    r = acc[RES_W-1:0];
  end

endmodule

// File: rtl/x_300_mod_241_stream.sv
// Streaming front-end for the 300-bit mod-241 reducer.
// Collects up to ten 32-bit words (LSB-first) into a 300-bit operand, then
// registers X mod 241 and offers it on a valid/ready output.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of the word/residue handshake bundle
module x_300_mod_241_stream
  import x_mod_241_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  x_300_mod_241_stream_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [N_BITS-1:0]  x_q, x_d;
  logic               trunc_q, trunc_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               res_trunc_q, res_trunc_d;
  logic [RES_W-1:0]   red_r;
  logic               in_fire;
  logic               last_beat;

  x_300_mod_241 u_reducer (
    .x (x_q),
    .r (red_r)
  );

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_res   = res_q;
  assign bus.out_trunc = res_trunc_q;

  assign in_fire   = bus.in_valid && (state_q == COLLECT);
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    x_d         = x_q;
    trunc_d     = trunc_q;
    res_d       = res_q;
    res_trunc_d = res_trunc_q;

    unique case (state_q)
      COLLECT: begin
        if (in_fire) begin
          // First beat wipes the previous operand so short frames read as zero-extended.
          if (beat_q == '0) begin
            x_d     = '0;
            trunc_d = 1'b0;
          end
          for (int k = 0; k < int'(BEATS) - 1; k++) begin
            if (beat_q == CNT_W'(k)) begin
              x_d[k*WORD_W +: WORD_W] = bus.in_data;
            end
          end
          if (last_beat) begin
            x_d[N_BITS-1 -: LAST_W] = bus.in_data[LAST_W-1:0];
            trunc_d                 = |bus.in_data[WORD_W-1:LAST_W];
          end
          beat_d = beat_q + CNT_W'(1);
          if (bus.in_last || last_beat) begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        res_d       = red_r;
        res_trunc_d = trunc_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          beat_d  = '0;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      beat_q      <= '0;
      x_q         <= '0;
      trunc_q     <= 1'b0;
      res_q       <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      x_q         <= x_d;
      trunc_q     <= trunc_d;
      res_q       <= res_d;
      res_trunc_q <= res_trunc_d;
    end
  end

endmodule

// File: tb/tb_x_300_mod_241_stream.sv
// Directed bench for x_300_mod_241_stream: hand-computed residues,
// latency, back-pressure hold, frame-start clear and mid-frame reset.
module tb_x_300_mod_241_stream;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  x_300_mod_241_stream_if bus ();

  x_300_mod_241_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
  endtask

  // Ten-word frame: beats 0..8 carry lo, beat 9 carries hi (implicit last).
  task automatic send_ten(input logic [31:0] lo, input logic [31:0] hi);
    for (int k = 0; k < 9; k++) send(lo, 1'b0);
    send(hi, 1'b0);
  endtask

  // Waits (bounded) for a result, checks it, then completes the handshake.
  task automatic take(input string tag, input logic [7:0] res, input logic trunc);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"}, 32'(bus.out_res), 32'(res));
    chk({tag, "_trunc"}, 32'(bus.out_trunc), 32'(trunc));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_res", 32'(bus.out_res), 32'd0);
    chk("rst_out_trunc", 32'(bus.out_trunc), 32'd0);
    rst_n = 1'b1;
    tick();

    // 241 mod 241 = 0; one CALC cycle then HOLD.
    send(32'h0000_00F1, 1'b1);
    chk("lat_calc_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_calc_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("lat_hold_valid", 32'(bus.out_valid), 32'd1);
    take("f1", 8'd0, 1'b0);

    // 2^32-1: 2^32 = 15 mod 241, so 14.
    send(32'hFFFF_FFFF, 1'b1);
    take("ffff", 8'd14, 1'b0);
    send(32'h0000_00F0, 1'b1);
    take("f0", 8'd240, 1'b0);

    // 2^300-1: 2^24 = 1 and 2^12 = 240 mod 241, so 2^300 = -1, result 239.
    send_ten(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    take("all_ones_trunc", 8'd239, 1'b1);
    send_ten(32'hFFFF_FFFF, 32'h0000_0FFF);
    take("all_ones_clean", 8'd239, 1'b0);

    // 2^299 = -1/2 = 120 mod 241; then a short frame must not see stale bits.
    send_ten(32'h0000_0000, 32'h0000_0800);
    take("pow299", 8'd120, 1'b0);
    send(32'h0000_0005, 1'b1);
    take("clear", 8'd5, 1'b0);

    // Back-pressure: result and flags stay put while out_ready is low.
    send_ten(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_res", 32'(bus.out_res), 32'd239);
      chk("hold_trunc", 32'(bus.out_trunc), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    take("hold_release", 8'd239, 1'b1);

    // Leave a nonzero result in out_res, then reset during beat 4.
    send(32'h0000_0007, 1'b1);
    take("pre_rst", 8'd7, 1'b0);
    for (int k = 0; k < 4; k++) send(32'h1234_5678, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    rst_n        = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_res", 32'(bus.out_res), 32'd0);
    chk("mid_rst_out_trunc", 32'(bus.out_trunc), 32'd0);
    rst_n = 1'b1;
    tick();
    // 242 mod 241 = 1; also shows the beat counter restarted at 0.
    send(32'h0000_00F2, 1'b1);
    take("post_rst", 8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
